// File: rtl/fir_stim_pkg.sv
// -----------------------------------------------------------------------------
// fir_stim_pkg
// Shared types and constants for the FIR stimulus generator.
//   - default sample / length widths
//   - mode encodings and FSM state type
//   - PRBS LFSR seed and tap positions (x^9 + x^5 + 1)
// Optional feature macro used by the design: FIR_STIM_PRBS_EN
// -----------------------------------------------------------------------------
package fir_stim_pkg;

    localparam int NB_INPUT_DEF = 8;
    localparam int NB_LEN_DEF   = 10;

    typedef enum logic [1:0] {
        IMPULSE = 2'd0,
        STEP    = 2'd1,
        RAMP    = 2'd2,
        PRBS    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         LFSR_W      = 9;
    localparam logic [8:0] LFSR_SEED   = 9'h1FF;
    localparam int         LFSR_TAP_HI = 8;
    localparam int         LFSR_TAP_LO = 4;

endpackage

// File: rtl/fir_stim_lfsr.sv
// -----------------------------------------------------------------------------
// fir_stim_lfsr
// 9-bit Fibonacci LFSR, x^9 + x^5 + 1, next = {q[7:0], q[8]^q[4]}.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears the register)
//   load      : reseed with LFSR_SEED on this edge
//   advance   : step one position on this edge
//   bit0      : bit 0 of the state the register takes on this edge, so the
//               parent can register the matching sample in the same cycle
// Only instantiated when FIR_STIM_PRBS_EN is defined.
// -----------------------------------------------------------------------------
module fir_stim_lfsr
    import fir_stim_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic advance,
    output logic bit0
);

    logic [LFSR_W-1:0] q;
    logic              fb;

    assign fb = q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO];

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= LFSR_SEED;
        end else if (advance) begin
            q <= {q[LFSR_W-2:0], fb};
        end
    end

    always_comb begin
        bit0 = q[0];
        if (load) begin
            bit0 = LFSR_SEED[0];
        end else if (advance) begin
            bit0 = fb;
        end
    end

endmodule

// File: rtl/fir_stim_gen.sv
// -----------------------------------------------------------------------------
// fir_stim_gen
// Programmable sample source for the FIR input: impulse, step, saturating
// ramp and (with FIR_STIM_PRBS_EN defined) PRBS. One signed sample per clock
// for a programmed number of samples, ending with a one-cycle done pulse.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : run request, only honoured in IDLE
//   abort       : terminate run, only honoured in RUN
//   mode        : 0 impulse, 1 step, 2 ramp, 3 PRBS
//   amplitude   : signed amplitude, latched at accepted start
//   length      : samples per run, latched at accepted start
//   x           : registered signed sample
//   x_valid     : x carries a run sample
//   sample_idx  : 0-based index of current sample
//   busy        : high in RUN
//   done        : one-cycle pulse at normal completion
//
// Macro: FIR_STIM_PRBS_EN -- when undefined, mode 3 runs with x = 0 and no
// LFSR is built.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs held at 0
// RUN   | emitting samples 0 .. length-1
// DONE  | done pulse cycle, returns to IDLE
// -----------------------------------------------------------------------------
module fir_stim_gen
    import fir_stim_pkg::*;
#(
    parameter int NB_INPUT = NB_INPUT_DEF,
    parameter int NB_LEN   = NB_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [1:0]                 mode,
    input  logic signed [NB_INPUT-1:0] amplitude,
    input  logic [NB_LEN-1:0]          length,
    output logic signed [NB_INPUT-1:0] x,
    output logic                       x_valid,
    output logic [NB_LEN-1:0]          sample_idx,
    output logic                       busy,
    output logic                       done
);

    localparam logic signed [NB_INPUT-1:0] X_MAX = {1'b0, {(NB_INPUT-1){1'b1}}};
    localparam logic signed [NB_INPUT-1:0] X_MIN = {1'b1, {(NB_INPUT-1){1'b0}}};

    state_t                     state, state_next;
    mode_t                      mode_q, mode_next;
    logic signed [NB_INPUT-1:0] amp_q, amp_next;
    logic [NB_LEN-1:0]          len_q, len_next;
    logic signed [NB_INPUT-1:0] x_next;
    logic [NB_LEN-1:0]          idx_next;
    logic                       valid_next, busy_next, done_next;
    logic                       last_sample, run_load, run_step;

    assign last_sample = (sample_idx == len_q - NB_LEN'(1));
    assign run_load    = (state == IDLE) && start && (length != '0);
    assign run_step    = (state == RUN) && !abort && !last_sample;

    // The ramp uses the previously emitted (already clipped) sample as its
    // accumulator, so a clipped ramp naturally holds at the rail.
    function automatic logic signed [NB_INPUT-1:0] sat_add(
        input logic signed [NB_INPUT-1:0] a,
        input logic signed [NB_INPUT-1:0] b
    );
        logic signed [NB_INPUT:0] sum;
        sum = {a[NB_INPUT-1], a} + {b[NB_INPUT-1], b};
        if (sum[NB_INPUT] != sum[NB_INPUT-1]) begin
            return sum[NB_INPUT] ? X_MIN : X_MAX;
        end
        return sum[NB_INPUT-1:0];
    endfunction

    function automatic logic signed [NB_INPUT-1:0] gen_sample(
        input mode_t                      m,
        input logic signed [NB_INPUT-1:0] amp,
        input logic                       first,
        input logic signed [NB_INPUT-1:0] prev
    );
        case (m)
            IMPULSE: return first ? amp : '0;
            STEP:    return amp;
            RAMP:    return first ? amp : sat_add(prev, amp);
            default: return '0;
        endcase
    endfunction

`ifdef FIR_STIM_PRBS_EN
    logic prbs_bit;

    fir_stim_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (run_load),
        .advance (run_step),
        .bit0    (prbs_bit)
    );

    // -A of the most negative code does not exist; clip it to the top rail.
    function automatic logic signed [NB_INPUT-1:0] neg_sat(
        input logic signed [NB_INPUT-1:0] a
    );
        return (a == X_MIN) ? X_MAX : -a;
    endfunction
`endif

    always_comb begin
        state_next = state;
        mode_next  = mode_q;
        amp_next   = amp_q;
        len_next   = len_q;
        x_next     = '0;
        valid_next = 1'b0;
        idx_next   = '0;
        busy_next  = 1'b0;
        done_next  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    mode_next = mode_t'(mode);
                    amp_next  = amplitude;
                    len_next  = length;
                    if (run_load) begin
                        state_next = RUN;
                        valid_next = 1'b1;
                        busy_next  = 1'b1;
                        x_next     = gen_sample(mode_t'(mode), amplitude, 1'b1, x);
                    end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_sample) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    idx_next   = sample_idx + NB_LEN'(1);
                    x_next     = gen_sample(mode_q, amp_q, 1'b0, x);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifdef FIR_STIM_PRBS_EN
        if (valid_next && (mode_next == PRBS)) begin
            x_next = prbs_bit ? amp_next : neg_sat(amp_next);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= IMPULSE;
            amp_q      <= '0;
            len_q      <= '0;
            x          <= '0;
            x_valid    <= 1'b0;
            sample_idx <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            mode_q     <= mode_next;
            amp_q      <= amp_next;
            len_q      <= len_next;
            x          <= x_next;
            x_valid    <= valid_next;
            sample_idx <= idx_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

endmodule
